// File: rtl/pipeline_stall_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_stall_controller_pkg
// Brief   : Shared state encoding and PC-source select codes for the stall
//           controller and the PC mux.
// Revision: 1.0
// ============================================================================
package pipeline_stall_controller_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        INT_PUSH = 2'd2,
        INT_VEC  = 2'd3
    } state_e;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_VEC = 2'b10;

    // Counter width for the longer of the two sequences, never narrower than 1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_stall_controller_counter.sv
`default_nettype none
// ============================================================================
// Module  : stall_cycle_counter
// Brief   : Loadable up-counter with clear and terminal-count compare.
// Revision: 1.0
// ============================================================================
module stall_cycle_counter #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] term_val,
    output logic [CNT_W-1:0] cnt,
    output logic             at_term
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign at_term = (cnt_q == term_val);

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_stall_controller
// Brief   : Stall/flush sequencer: load-use freeze, branch flush and
//           multi-cycle interrupt entry (PC push, then vector fetch).
// Revision: 1.0
// ============================================================================
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter  int STALL_CYCLES = 1,
    parameter  int INT_CYCLES   = 2,
    localparam int CNT_W        = cnt_width(STALL_CYCLES, INT_CYCLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_hazard,
    input  logic             branch_taken,
    input  logic             int_req,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [1:0]       pc_sel,
    output logic             stack_push,
    output logic [CNT_W-1:0] push_word,
    output logic             int_ack,
    output logic             busy
);

    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] INT_LAST   = CNT_W'(INT_CYCLES - 1);

    state_e           state_q, state_d;
    logic             pending_q, pending_d;
    logic             cnt_clr, cnt_inc, cnt_load, at_term;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] term_val;

    assign term_val = (state_q == INT_PUSH) ? INT_LAST : STALL_LAST;

    stall_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .load     (cnt_load),
        .load_val (CNT_W'(1)),
        .term_val (term_val),
        .cnt      (cnt),
        .at_term  (at_term)
    );

    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q | int_req;
        cnt_clr        = 1'b0;
        cnt_inc        = 1'b0;
        cnt_load       = 1'b0;
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        pc_sel         = PC_INC;
        stack_push     = 1'b0;
        push_word      = '0;
        int_ack        = 1'b0;
        busy           = (state_q != RUN);

        unique case (state_q)
            RUN: begin
                if (branch_taken) begin
                    pc_sel       = PC_BR;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (ld_hazard) begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    id_ex_bubble   = 1'b1;
                    if (STALL_CYCLES > 1) begin
                        state_d  = LD_STALL;
                        cnt_load = 1'b1;
                    end
                end else if (pending_q) begin
                    state_d = INT_PUSH;
                    cnt_clr = 1'b1;
                end
            end
            LD_STALL: begin
                // A taken branch squashes the stalled instruction anyway.
                if (branch_taken) begin
                    pc_sel       = PC_BR;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    state_d      = RUN;
                    cnt_clr      = 1'b1;
                end else begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    id_ex_bubble   = 1'b1;
                    if (at_term) begin
                        state_d = RUN;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            INT_PUSH: begin
                pc_write_en  = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                stack_push   = 1'b1;
                push_word    = cnt;
                if (at_term) begin
                    state_d = INT_VEC;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            INT_VEC: begin
                pc_sel       = PC_VEC;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                int_ack      = 1'b1;
                pending_d    = int_req;
                state_d      = RUN;
                cnt_clr      = 1'b1;
            end
            default: begin
                state_d = RUN;
                cnt_clr = 1'b1;
            end
        endcase

        if (reset) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            if_id_flush    = 1'b1;
            id_ex_bubble   = 1'b1;
            pc_sel         = PC_INC;
            stack_push     = 1'b0;
            push_word      = '0;
            int_ack        = 1'b0;
            busy           = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    // EX only ever holds bubbles during interrupt entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(branch_taken && (state_q == INT_PUSH || state_q == INT_VEC)));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_stall_controller
// Brief   : Directed bench for two controller instances (1- and 3-cycle stall).
// Revision: 1.0
// ============================================================================
module tb_pipeline_stall_controller;

    // {pc_we, if_id_we, flush, bubble, pc_sel[1:0], push, push_word[1:0], ack, busy}
    localparam logic [10:0] RST  = 11'b0_0_1_1_00_0_00_0_0;
    localparam logic [10:0] DEF  = 11'b1_1_0_0_00_0_00_0_0;
    localparam logic [10:0] FRZ0 = 11'b0_0_0_1_00_0_00_0_0;
    localparam logic [10:0] FRZ1 = 11'b0_0_0_1_00_0_00_0_1;
    localparam logic [10:0] BR0  = 11'b1_1_1_1_01_0_00_0_0;
    localparam logic [10:0] BR1  = 11'b1_1_1_1_01_0_00_0_1;
    localparam logic [10:0] PSH0 = 11'b0_1_1_1_00_1_00_0_1;
    localparam logic [10:0] PSH1 = 11'b0_1_1_1_00_1_01_0_1;
    localparam logic [10:0] VEC  = 11'b1_1_1_1_10_0_00_1_1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic a_ld = 1'b0, a_br = 1'b0, a_int = 1'b0;
    logic b_ld = 1'b0, b_br = 1'b0, b_int = 1'b0;

    logic       a_pcwe, a_ifwe, a_fl, a_bub, a_sp, a_ack, a_busy;
    logic [1:0] a_sel;
    logic [0:0] a_pw;
    logic       b_pcwe, b_ifwe, b_fl, b_bub, b_sp, b_ack, b_busy;
    logic [1:0] b_sel;
    logic [1:0] b_pw;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.STALL_CYCLES(1), .INT_CYCLES(2)) dut1 (
        .clk(clk), .reset(reset), .ld_hazard(a_ld), .branch_taken(a_br), .int_req(a_int),
        .pc_write_en(a_pcwe), .if_id_write_en(a_ifwe), .if_id_flush(a_fl),
        .id_ex_bubble(a_bub), .pc_sel(a_sel), .stack_push(a_sp), .push_word(a_pw),
        .int_ack(a_ack), .busy(a_busy)
    );

    pipeline_stall_controller #(.STALL_CYCLES(3), .INT_CYCLES(2)) dut3 (
        .clk(clk), .reset(reset), .ld_hazard(b_ld), .branch_taken(b_br), .int_req(b_int),
        .pc_write_en(b_pcwe), .if_id_write_en(b_ifwe), .if_id_flush(b_fl),
        .id_ex_bubble(b_bub), .pc_sel(b_sel), .stack_push(b_sp), .push_word(b_pw),
        .int_ack(b_ack), .busy(b_busy)
    );

    wire logic [10:0] obs_a = {a_pcwe, a_ifwe, a_fl, a_bub, a_sel, a_sp, 1'b0, a_pw, a_ack, a_busy};
    wire logic [10:0] obs_b = {b_pcwe, b_ifwe, b_fl, b_bub, b_sel, b_sp, b_pw, b_ack, b_busy};

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc_a(input logic ld, input logic br, input logic irq);
        @(posedge clk); #1;
        a_ld = ld; a_br = br; a_int = irq;
        @(negedge clk);
    endtask

    task automatic cyc_b(input logic ld, input logic br, input logic irq);
        @(posedge clk); #1;
        b_ld = ld; b_br = br; b_int = irq;
        @(negedge clk);
    endtask

    initial begin
        // Power-on reset, two cycles
        @(negedge clk);
        chk("rst_a0", obs_a, RST);  chk("rst_b0", obs_b, RST);
        @(posedge clk); #1; @(negedge clk);
        chk("rst_a1", obs_a, RST);  chk("rst_b1", obs_b, RST);
        @(posedge clk); #1; reset = 1'b0; @(negedge clk);
        chk("idle_a", obs_a, DEF);  chk("idle_b", obs_b, DEF);

        // Single-cycle load-use stall
        cyc_a(1, 0, 0); chk("ld1_frz", obs_a, FRZ0);
        cyc_a(0, 0, 0); chk("ld1_after", obs_a, DEF);

        // Branch beats hazard
        cyc_a(1, 1, 0); chk("brld_a", obs_a, BR0);
        cyc_a(0, 0, 0); chk("brld_after", obs_a, DEF);

        // Interrupt entry: pending cycle, two pushes, vector, back to run
        cyc_a(0, 0, 1); chk("int_req", obs_a, DEF);
        cyc_a(0, 0, 0); chk("int_pend", obs_a, DEF);
        cyc_a(0, 0, 0); chk("int_push0", obs_a, PSH0);
        cyc_a(0, 0, 0); chk("int_push1", obs_a, PSH1);
        cyc_a(0, 0, 0); chk("int_vec", obs_a, VEC);
        cyc_a(0, 0, 0); chk("int_done", obs_a, DEF);
        cyc_a(0, 0, 0); chk("int_quiet", obs_a, DEF);

        // Reset during INT_PUSH with cnt=1 drops the sequence and the pending flag
        cyc_a(0, 0, 1); chk("ri_req", obs_a, DEF);
        cyc_a(0, 0, 0); chk("ri_pend", obs_a, DEF);
        cyc_a(0, 0, 0); chk("ri_push0", obs_a, PSH0);
        @(posedge clk); #1; reset = 1'b1; @(negedge clk);
        chk("ri_rst0", obs_a, RST);
        @(posedge clk); #1; @(negedge clk);
        chk("ri_rst1", obs_a, RST);
        @(posedge clk); #1; reset = 1'b0; @(negedge clk);
        chk("ri_rel0", obs_a, DEF);
        cyc_a(0, 0, 0); chk("ri_rel1", obs_a, DEF);
        cyc_a(0, 0, 0); chk("ri_rel2", obs_a, DEF);

        // Three-cycle stall
        cyc_b(1, 0, 0); chk("ld3_c1", obs_b, FRZ0);
        cyc_b(0, 0, 0); chk("ld3_c2", obs_b, FRZ1);
        cyc_b(0, 0, 0); chk("ld3_c3", obs_b, FRZ1);
        cyc_b(0, 0, 0); chk("ld3_done", obs_b, DEF);

        // Branch aborts the stall at cnt=1
        cyc_b(1, 0, 0); chk("ab_c1", obs_b, FRZ0);
        cyc_b(0, 1, 0); chk("ab_br", obs_b, BR1);
        cyc_b(0, 0, 0); chk("ab_run", obs_b, DEF);

        // Interrupt deferred behind a stall, re-raised during INT_VEC
        cyc_b(1, 0, 0); chk("df_c1", obs_b, FRZ0);
        cyc_b(0, 0, 1); chk("df_c2", obs_b, FRZ1);
        cyc_b(0, 0, 0); chk("df_c3", obs_b, FRZ1);
        cyc_b(0, 0, 0); chk("df_run", obs_b, DEF);
        cyc_b(0, 0, 0); chk("df_push0", obs_b, PSH0);
        cyc_b(0, 0, 0); chk("df_push1", obs_b, PSH1);
        cyc_b(0, 0, 1); chk("df_vec", obs_b, VEC);
        cyc_b(0, 0, 0); chk("df2_run", obs_b, DEF);
        cyc_b(0, 0, 0); chk("df2_push0", obs_b, PSH0);
        cyc_b(0, 0, 0); chk("df2_push1", obs_b, PSH1);
        cyc_b(0, 0, 0); chk("df2_vec", obs_b, VEC);
        cyc_b(0, 0, 0); chk("df2_done", obs_b, DEF);
        cyc_b(0, 0, 0); chk("df2_quiet", obs_b, DEF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
